sram_ctrl_ws: RTL and testbench

- Parametrised next-generation SRAM controller with a valid/ready CPU request port, byte enables, a programmable number of wait states and a one-cycle response pulse.
- Sits between the CPU memory stage and the external/on-chip SRAM macro.
- Handles one outstanding access at a time.
- Captures read data correctly on the final strobe cycle; writes never disturb the read-data register.

---
 rtl/sram_ctrl_pkg.sv | 22 ++
 rtl/sram_ctrl_ws_if.sv | 46 ++++
 rtl/sram_ws_counter.sv | 35 +++
 rtl/sram_ctrl_ws.sv | 144 ++++++++++++++
 tb/tb_sram_ctrl_ws.sv | 268 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/sram_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sram_ctrl_pkg
// Description : Shared constants for the wait-state SRAM controller: FSM
//               encodings, wait-counter width and default geometry.
// Revision    : 1.0 - initial release
// ============================================================================
package sram_ctrl_pkg;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ACCESS = 2'd1;
    localparam logic [1:0] ST_RESP   = 2'd2;

    localparam int WS_CNT_W = 4;

    localparam int DEF_ADDR_W      = 20;
    localparam int DEF_DATA_W      = 32;
    localparam int DEF_WAIT_CYCLES = 1;
    localparam int DEF_MEM_WORDS   = 1 << 20;

endpackage
`default_nettype wire

// File: rtl/sram_ctrl_ws_if.sv
`default_nettype none
// ============================================================================
// Module      : sram_ctrl_ws_if
// Description : CPU request/response and SRAM macro signals of the controller.
//               slave = controller side, master = CPU + SRAM side.
// Revision    : 1.0 - initial release
// ============================================================================
interface sram_ctrl_ws_if
    import sram_ctrl_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
) ();

    localparam int BE_W = DATA_W / 8;

    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic [BE_W-1:0]   req_be;
    logic              rsp_valid;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_err;
    logic [ADDR_W-1:0] sram_addr;
    logic [DATA_W-1:0] sram_wdata;
    logic [BE_W-1:0]   sram_be;
    logic              sram_we;
    logic              sram_re;
    logic [DATA_W-1:0] sram_rdata;

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, req_be, sram_rdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_err,
        output sram_addr, sram_wdata, sram_be, sram_we, sram_re
    );

    modport master (
        output req_valid, req_we, req_addr, req_wdata, req_be, sram_rdata,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err,
        input  sram_addr, sram_wdata, sram_be, sram_we, sram_re
    );

endinterface
`default_nettype wire

// File: rtl/sram_ws_counter.sv
`default_nettype none
// ============================================================================
// Module      : sram_ws_counter
// Description : Loadable down-counter with zero flag, times the strobe phase.
// Revision    : 1.0 - initial release
// ============================================================================
module sram_ws_counter
    import sram_ctrl_pkg::*;
#(
    parameter int WIDTH = WS_CNT_W
) (
    input  wire logic             clk,
    input  wire logic             rst_n,
    input  wire logic             load,
    input  wire logic [WIDTH-1:0] load_val,
    input  wire logic             dec,
    output logic                  zero
);

    logic [WIDTH-1:0] r_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (load) begin
            r_count <= load_val;
        end else if (dec) begin
            r_count <= r_count - 1'b1;
        end
    end

    assign zero = (r_count == '0);

endmodule
`default_nettype wire

// File: rtl/sram_ctrl_ws.sv
`default_nettype none
// ============================================================================
// Module      : sram_ctrl_ws
// Description : Single-outstanding SRAM controller with programmable wait
//               states. Define SRAM_CTRL_RANGE_CHK_EN to reject addresses
//               at or beyond MEM_WORDS with rsp_err.
// Revision    : 1.0 - initial release
// ============================================================================
module sram_ctrl_ws
    import sram_ctrl_pkg::*;
#(
    parameter int ADDR_W      = DEF_ADDR_W,
    parameter int DATA_W      = DEF_DATA_W,
    parameter int WAIT_CYCLES = DEF_WAIT_CYCLES,
    parameter int MEM_WORDS   = DEF_MEM_WORDS
) (
    input  wire logic     clk,
    input  wire logic     rst_n,
    sram_ctrl_ws_if.slave bus
);

    localparam int                  BE_W      = DATA_W / 8;
    localparam logic [WS_CNT_W-1:0] C_WAIT_LD = WS_CNT_W'(WAIT_CYCLES);

    if (DATA_W % 8 != 0 || WAIT_CYCLES < 0 || WAIT_CYCLES > 15 || MEM_WORDS < 1) begin : g_bad_params
        $error("sram_ctrl_ws: illegal parameter combination");
    end

    logic [1:0]        r_state;
    logic [ADDR_W-1:0] r_sram_addr;
    logic [DATA_W-1:0] r_sram_wdata;
    logic [BE_W-1:0]   r_sram_be;
    logic              r_sram_we;
    logic              r_sram_re;
    logic              r_rsp_valid;
    logic [DATA_W-1:0] r_rsp_rdata;

    logic w_accept;
    logic w_range_err;
    logic w_cnt_load;
    logic w_cnt_dec;
    logic w_cnt_zero;

    assign w_accept = (r_state == ST_IDLE) && bus.req_valid;

`ifdef SRAM_CTRL_RANGE_CHK_EN
    localparam logic [32:0] C_MEM_WORDS = 33'(MEM_WORDS);

    logic r_rsp_err;

    assign w_range_err = (33'(bus.req_addr) >= C_MEM_WORDS);

    // Error flag is only ever set alongside the direct IDLE->RESP hop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rsp_err <= 1'b0;
        end else if (w_accept) begin
            r_rsp_err <= w_range_err;
        end else if (r_state == ST_RESP) begin
            r_rsp_err <= 1'b0;
        end
    end

    assign bus.rsp_err = r_rsp_err;
`else
    assign w_range_err = 1'b0;
    assign bus.rsp_err = 1'b0;
`endif

    assign w_cnt_load = w_accept && !w_range_err;
    assign w_cnt_dec  = (r_state == ST_ACCESS) && !w_cnt_zero;

    sram_ws_counter #(
        .WIDTH (WS_CNT_W)
    ) u_ws_counter (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (w_cnt_load),
        .load_val (C_WAIT_LD),
        .dec      (w_cnt_dec),
        .zero     (w_cnt_zero)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_sram_addr  <= '0;
            r_sram_wdata <= '0;
            r_sram_be    <= '0;
            r_sram_we    <= 1'b0;
            r_sram_re    <= 1'b0;
            r_rsp_valid  <= 1'b0;
            r_rsp_rdata  <= '0;
        end else begin
            r_rsp_valid <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        if (w_range_err) begin
                            r_state     <= ST_RESP;
                            r_rsp_valid <= 1'b1;
                        end else begin
                            r_sram_addr  <= bus.req_addr;
                            r_sram_wdata <= bus.req_wdata;
                            r_sram_be    <= bus.req_we ? bus.req_be : {BE_W{1'b1}};
                            r_sram_we    <= bus.req_we;
                            r_sram_re    <= !bus.req_we;
                            r_state      <= ST_ACCESS;
                        end
                    end
                end
                ST_ACCESS: begin
                    // SRAM data is only guaranteed at the end of the last strobe cycle.
                    if (w_cnt_zero) begin
                        if (r_sram_re) begin
                            r_rsp_rdata <= bus.sram_rdata;
                        end
                        r_sram_we   <= 1'b0;
                        r_sram_re   <= 1'b0;
                        r_rsp_valid <= 1'b1;
                        r_state     <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.req_ready  = (r_state == ST_IDLE);
    assign bus.rsp_valid  = r_rsp_valid;
    assign bus.rsp_rdata  = r_rsp_rdata;
    assign bus.sram_addr  = r_sram_addr;
    assign bus.sram_wdata = r_sram_wdata;
    assign bus.sram_be    = r_sram_be;
    assign bus.sram_we    = r_sram_we;
    assign bus.sram_re    = r_sram_re;

endmodule
`default_nettype wire

// File: tb/tb_sram_ctrl_ws.sv
`default_nettype none
// ============================================================================
// Module      : tb_sram_ctrl_ws
// Description : Directed bench; three controllers with WAIT_CYCLES 0/1/2
//               share one behavioural SRAM model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sram_ctrl_ws;

    localparam int AW   = 20;
    localparam int DW   = 32;
    localparam int BW   = 4;
    localparam int ND   = 3;
    localparam int MEMW = 1024;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic          req_valid [ND];
    logic          req_we    [ND];
    logic [AW-1:0] req_addr  [ND];
    logic [DW-1:0] req_wdata [ND];
    logic [BW-1:0] req_be    [ND];
    logic          req_ready [ND];
    logic          rsp_valid [ND];
    logic          rsp_err   [ND];
    logic [DW-1:0] rsp_rdata [ND];
    logic [AW-1:0] s_addr    [ND];
    logic [DW-1:0] s_wdata   [ND];
    logic [BW-1:0] s_be      [ND];
    logic          s_we      [ND];
    logic          s_re      [ND];

    logic [DW-1:0] mem [MEMW];

    for (genvar i = 0; i < ND; i++) begin : g_dut
        sram_ctrl_ws_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

        assign bus.req_valid  = req_valid[i];
        assign bus.req_we     = req_we[i];
        assign bus.req_addr   = req_addr[i];
        assign bus.req_wdata  = req_wdata[i];
        assign bus.req_be     = req_be[i];
        assign bus.sram_rdata = mem[bus.sram_addr[9:0]];
        assign req_ready[i]   = bus.req_ready;
        assign rsp_valid[i]   = bus.rsp_valid;
        assign rsp_err[i]     = bus.rsp_err;
        assign rsp_rdata[i]   = bus.rsp_rdata;
        assign s_addr[i]      = bus.sram_addr;
        assign s_wdata[i]     = bus.sram_wdata;
        assign s_be[i]        = bus.sram_be;
        assign s_we[i]        = bus.sram_we;
        assign s_re[i]        = bus.sram_re;

        sram_ctrl_ws #(
            .ADDR_W      (AW),
            .DATA_W      (DW),
            .WAIT_CYCLES (i),
            .MEM_WORDS   (MEMW)
        ) u_dut (
            .clk   (clk),
            .rst_n (rst_n),
            .bus   (bus)
        );
    end

    // Byte-masked write on every strobed edge; a few words preloaded while in reset.
    always @(posedge clk) begin
        if (!rst_n) begin
            mem[10'h020] <= 32'hA5A5_5A5A;
            mem[10'h3FF] <= 32'h0BAD_F00D;
            mem[10'h000] <= 32'h1357_9BDF;
        end else begin
            for (int d = 0; d < ND; d++) begin
                if (s_we[d]) begin
                    for (int b = 0; b < BW; b++) begin
                        if (s_be[d][b]) mem[s_addr[d][9:0]][8*b +: 8] <= s_wdata[d][8*b +: 8];
                    end
                end
            end
        end
    end

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    typedef struct {
        int            d;
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [BW-1:0] be;
        logic [DW-1:0] exp_rdata;
        logic          exp_err;
        int            exp_strb;
        int            exp_lat;
        logic [BW-1:0] exp_sbe;
    } vec_t;

    vec_t vecs [10];

    // lat = rising edges from the accepting edge to the edge that first samples rsp_valid=1
    task automatic run_vec(input vec_t v, input int idx);
        int            strb      = 0;
        int            lat       = 0;
        logic          done      = 1'b0;
        logic          bad_kind  = 1'b0;
        logic [BW-1:0] sbe       = '0;
        logic [AW-1:0] sad       = '0;
        logic          err_s     = 1'b0;
        logic [DW-1:0] rd_s      = '0;
        @(negedge clk);
        check($sformatf("v%0d_ready_before", idx), req_ready[v.d], 1);
        req_valid[v.d] = 1'b1;
        req_we[v.d]    = v.we;
        req_addr[v.d]  = v.addr;
        req_wdata[v.d] = v.wdata;
        req_be[v.d]    = v.be;
        @(posedge clk);
        #1;
        req_valid[v.d] = 1'b0;
        req_we[v.d]    = ~v.we;
        req_addr[v.d]  = '1;
        req_wdata[v.d] = '1;
        req_be[v.d]    = '1;
        for (int j = 0; j < 20 && !done; j++) begin
            @(negedge clk);
            if (s_we[v.d] || s_re[v.d]) begin
                strb++;
                sbe = s_be[v.d];
                sad = s_addr[v.d];
                if ((s_we[v.d] && s_re[v.d]) || (s_we[v.d] !== v.we)) bad_kind = 1'b1;
            end
            if (rsp_valid[v.d]) begin
                done  = 1'b1;
                lat   = j + 1;
                err_s = rsp_err[v.d];
                rd_s  = rsp_rdata[v.d];
            end
        end
        check($sformatf("v%0d_rsp_seen", idx), done, 1);
        check($sformatf("v%0d_strobe_cycles", idx), strb, v.exp_strb);
        check($sformatf("v%0d_latency", idx), lat, v.exp_lat);
        check($sformatf("v%0d_strobe_kind", idx), bad_kind, 0);
        check($sformatf("v%0d_rsp_err", idx), err_s, v.exp_err);
        check($sformatf("v%0d_rsp_rdata", idx), rd_s, v.exp_rdata);
        if (v.exp_strb > 0) begin
            check($sformatf("v%0d_sram_be", idx), sbe, v.exp_sbe);
            check($sformatf("v%0d_sram_addr", idx), sad, v.addr);
        end
        @(negedge clk);
        check($sformatf("v%0d_pulse_len", idx), rsp_valid[v.d], 0);
        check($sformatf("v%0d_ready_after", idx), req_ready[v.d], 1);
        check($sformatf("v%0d_rdata_held", idx), rsp_rdata[v.d], v.exp_rdata);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running, expected finish");
        $fatal(1);
    end

    initial begin
        int   rdy_pos [$];
        logic prev_rsp;
        logic seen;

        for (int d = 0; d < ND; d++) begin
            req_valid[d] = 1'b0;
            req_we[d]    = 1'b0;
            req_addr[d]  = '0;
            req_wdata[d] = '0;
            req_be[d]    = '0;
        end

        vecs[0] = '{1, 1'b1, 20'h00010, 32'hDEADBEEF, 4'hF, 32'h0000_0000, 1'b0, 2, 3, 4'hF};
        vecs[1] = '{0, 1'b0, 20'h00010, 32'h0,        4'h0, 32'hDEADBEEF,  1'b0, 1, 2, 4'hF};
        vecs[2] = '{1, 1'b1, 20'h00010, 32'h00AA0000, 4'h4, 32'h0000_0000, 1'b0, 2, 3, 4'h4};
        vecs[3] = '{0, 1'b0, 20'h00010, 32'h0,        4'h0, 32'hDEAABEEF,  1'b0, 1, 2, 4'hF};
        vecs[4] = '{2, 1'b1, 20'h00020, 32'h12345678, 4'h0, 32'h0000_0000, 1'b0, 3, 4, 4'h0};
        vecs[5] = '{2, 1'b0, 20'h00020, 32'h0,        4'h0, 32'hA5A55A5A,  1'b0, 3, 4, 4'hF};
        vecs[6] = '{1, 1'b0, 20'h003FF, 32'h0,        4'h0, 32'h0BADF00D,  1'b0, 2, 3, 4'hF};
`ifdef SRAM_CTRL_RANGE_CHK_EN
        vecs[7] = '{1, 1'b0, 20'h00400, 32'h0,        4'h0, 32'h0BADF00D,  1'b1, 0, 1, 4'hF};
`else
        vecs[7] = '{1, 1'b0, 20'h00400, 32'h0,        4'h0, 32'h13579BDF,  1'b0, 2, 3, 4'hF};
`endif
        vecs[8] = '{0, 1'b1, 20'h003FF, 32'hFF0000EE, 4'h9, 32'hDEAABEEF,  1'b0, 1, 2, 4'h9};
        vecs[9] = '{2, 1'b0, 20'h003FF, 32'h0,        4'h0, 32'hFFADF0EE,  1'b0, 3, 4, 4'hF};

        // Reset values, sampled while reset is still applied
        repeat (2) @(negedge clk);
        for (int d = 0; d < ND; d++) begin
            check($sformatf("rst%0d_req_ready", d), req_ready[d], 1);
            check($sformatf("rst%0d_sram_we", d), s_we[d], 0);
            check($sformatf("rst%0d_sram_re", d), s_re[d], 0);
            check($sformatf("rst%0d_rsp_valid", d), rsp_valid[d], 0);
            check($sformatf("rst%0d_rsp_err", d), rsp_err[d], 0);
            check($sformatf("rst%0d_rsp_rdata", d), rsp_rdata[d], 0);
            check($sformatf("rst%0d_sram_addr", d), s_addr[d], 0);
        end
        rst_n = 1'b1;

        // Reset in the middle of an access on the WAIT_CYCLES=1 instance
        @(negedge clk);
        req_valid[1] = 1'b1;
        req_we[1]    = 1'b0;
        req_addr[1]  = 20'h00010;
        @(posedge clk);
        #1;
        req_valid[1] = 1'b0;
        @(negedge clk);
        check("abort_strobe_before", s_re[1], 1);
        check("abort_ready_before", req_ready[1], 0);
        rst_n = 1'b0;
        #1;
        check("abort_re_async", s_re[1], 0);
        check("abort_we_async", s_we[1], 0);
        check("abort_ready_async", req_ready[1], 1);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        repeat (6) begin
            @(negedge clk);
            if (rsp_valid[1]) seen = 1'b1;
        end
        check("abort_no_rsp", seen, 0);

        for (int k = 0; k < 10; k++) run_vec(vecs[k], k);

        // Back-to-back reads with req_valid held on the WAIT_CYCLES=2 instance
        @(negedge clk);
        req_valid[2] = 1'b1;
        req_we[2]    = 1'b0;
        req_addr[2]  = 20'h00020;
        prev_rsp     = 1'b0;
        for (int j = 0; j < 17; j++) begin
            if (j > 0) @(negedge clk);
            if (rsp_valid[2]) check($sformatf("b2b_ready_low_at_rsp_%0d", j), req_ready[2], 0);
            if (req_ready[2]) begin
                rdy_pos.push_back(j);
                if (rdy_pos.size() > 1) check($sformatf("b2b_rsp_before_ready_%0d", j), prev_rsp, 1);
            end
            prev_rsp = rsp_valid[2];
        end
        req_valid[2] = 1'b0;
        check("b2b_accept_count", rdy_pos.size(), 4);
        for (int k = 1; k < rdy_pos.size(); k++) begin
            check($sformatf("b2b_gap_%0d", k), rdy_pos[k] - rdy_pos[k-1], 5);
        end
        repeat (6) @(negedge clk);
        check("b2b_final_rdata", rsp_rdata[2], 32'hA5A55A5A);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
